// File: rtl/sram_arbiter.sv
// Two-requester arbiter sharing one SRAM port between the VGA fetcher (priority)
// and the CPU load/store path. A bounded-wait counter guarantees CPU progress and
// a timeout counter aborts transactions stuck on mem_busy.
module sram_arbiter #(
  parameter int unsigned CPU_MAX_WAIT = 8,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        nrst,
  // VGA read port
  input  logic        vga_req,
  input  logic [31:0] vga_addr,
  output logic [31:0] vga_rdata,
  output logic        vga_busy,
  output logic        vga_done,
  // CPU load/store port
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byte_sel,
  output logic [31:0] cpu_rdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        err,
  // SRAM controller side
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_sel,
  input  logic [31:0] mem_rdata,
  input  logic        mem_busy,
  output logic [1:0]  grant
);

  localparam int unsigned WaitW = $clog2(CPU_MAX_WAIT + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(CPU_MAX_WAIT);
  // The abort fires on the edge that ends the TIMEOUT-th busy WAIT cycle.
  localparam logic [TmoW-1:0]  TmoLast = TmoW'(TIMEOUT - 1);

  localparam logic [1:0] GrantNone = 2'b00;
  localparam logic [1:0] GrantVga  = 2'b01;
  localparam logic [1:0] GrantCpu  = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait
  } state_e;

  state_e            state_q, state_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [1:0]        grant_q, grant_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_byte_sel_q, mem_byte_sel_d;
  logic [31:0]       vga_rdata_q, vga_rdata_d;
  logic              vga_busy_q, vga_busy_d;
  logic              vga_done_q, vga_done_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic              cpu_busy_q, cpu_busy_d;
  logic              cpu_done_q, cpu_done_d;
  logic              err_q, err_d;

  logic        any_req;
  logic        cpu_wins;
  logic        complete;
  logic        timeout;
  logic        finish;
  logic [31:0] rd_value;

  // Arbitration and completion conditions.
  always_comb begin
    any_req  = vga_req | cpu_req;
    cpu_wins = cpu_req & (~vga_req | (wait_cnt_q == WaitMax));
    complete = (state_q == StWait) & ~mem_busy;
    timeout  = (state_q == StWait) & mem_busy & (tmo_cnt_q == TmoLast);
    finish   = complete | timeout;
    // Writes and aborted transactions return zero data.
    rd_value = (mem_we_q | timeout) ? 32'h0 : mem_rdata;
  end

  // Next-state, transaction latch and completion logic.
  always_comb begin
    state_d        = state_q;
    tmo_cnt_d      = tmo_cnt_q;
    grant_d        = grant_q;
    mem_req_d      = 1'b0;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_byte_sel_d = mem_byte_sel_q;
    vga_rdata_d    = vga_rdata_q;
    vga_done_d     = 1'b0;
    cpu_rdata_d    = cpu_rdata_q;
    cpu_done_d     = 1'b0;
    err_d          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d   = StLaunch;
          mem_req_d = 1'b1;
          if (cpu_wins) begin
            grant_d        = GrantCpu;
            mem_we_d       = cpu_we;
            mem_addr_d     = cpu_addr;
            mem_wdata_d    = cpu_wdata;
            mem_byte_sel_d = cpu_byte_sel;
          end else begin
            grant_d        = GrantVga;
            mem_we_d       = 1'b0;
            mem_addr_d     = vga_addr;
            mem_wdata_d    = 32'h0;
            mem_byte_sel_d = 4'hF;
          end
        end
      end
      StLaunch: begin
        state_d   = StWait;
        tmo_cnt_d = '0;
      end
      StWait: begin
        if (finish) begin
          state_d   = StIdle;
          grant_d   = GrantNone;
          tmo_cnt_d = '0;
          err_d     = timeout;
          if (grant_q == GrantCpu) begin
            cpu_rdata_d = rd_value;
            cpu_done_d  = 1'b1;
          end else begin
            vga_rdata_d = rd_value;
            vga_done_d  = 1'b1;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = GrantNone;
      end
    endcase
  end

  // CPU starvation counter: counts ungranted request cycles, saturating.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!cpu_req) begin
      wait_cnt_d = '0;
    end else if ((grant_q == GrantCpu) || ((state_q == StIdle) && cpu_wins)) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WaitMax) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Busy: owner stays busy until its done cycle; a non-owner follows its request.
  always_comb begin
    vga_busy_d = (grant_q == GrantVga) ? ~finish : vga_req;
    cpu_busy_d = (grant_q == GrantCpu) ? ~finish : cpu_req;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q        <= StIdle;
      wait_cnt_q     <= '0;
      tmo_cnt_q      <= '0;
      grant_q        <= GrantNone;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= 32'h0;
      mem_wdata_q    <= 32'h0;
      mem_byte_sel_q <= 4'h0;
      vga_rdata_q    <= 32'h0;
      vga_busy_q     <= 1'b0;
      vga_done_q     <= 1'b0;
      cpu_rdata_q    <= 32'h0;
      cpu_busy_q     <= 1'b0;
      cpu_done_q     <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      grant_q        <= grant_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_byte_sel_q <= mem_byte_sel_d;
      vga_rdata_q    <= vga_rdata_d;
      vga_busy_q     <= vga_busy_d;
      vga_done_q     <= vga_done_d;
      cpu_rdata_q    <= cpu_rdata_d;
      cpu_busy_q     <= cpu_busy_d;
      cpu_done_q     <= cpu_done_d;
      err_q          <= err_d;
    end
  end

  assign grant        = grant_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_byte_sel = mem_byte_sel_q;
  assign vga_rdata    = vga_rdata_q;
  assign vga_busy     = vga_busy_q;
  assign vga_done     = vga_done_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign cpu_busy     = cpu_busy_q;
  assign cpu_done     = cpu_done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: reset, single reads/writes, contention,
// bounded CPU wait, timeout abort and asynchronous reset mid-transaction.
module tb_sram_arbiter;

  logic        clk;
  logic        nrst;
  logic        vga_req;
  logic [31:0] vga_addr;
  logic [31:0] vga_rdata;
  logic        vga_busy;
  logic        vga_done;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_byte_sel;
  logic [31:0] cpu_rdata;
  logic        cpu_busy;
  logic        cpu_done;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_sel;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  sram_arbiter #(
    .CPU_MAX_WAIT(8),
    .TIMEOUT     (64)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .vga_req     (vga_req),
    .vga_addr    (vga_addr),
    .vga_rdata   (vga_rdata),
    .vga_busy    (vga_busy),
    .vga_done    (vga_done),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_byte_sel(cpu_byte_sel),
    .cpu_rdata   (cpu_rdata),
    .cpu_busy    (cpu_busy),
    .cpu_done    (cpu_done),
    .err         (err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_byte_sel(mem_byte_sel),
    .mem_rdata   (mem_rdata),
    .mem_busy    (mem_busy),
    .grant       (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    nrst         = 1'b0;
    vga_req      = 1'b0;
    vga_addr     = 32'h0;
    cpu_req      = 1'b0;
    cpu_we       = 1'b0;
    cpu_addr     = 32'h0;
    cpu_wdata    = 32'h0;
    cpu_byte_sel = 4'h0;
    mem_rdata    = 32'h0;
    mem_busy     = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_grant", {30'h0, grant}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_busy", {30'h0, vga_busy, cpu_busy}, 32'h0);
    chk("rst_done_err", {29'h0, vga_done, cpu_done, err}, 32'h0);
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_no_req", {31'h0, mem_req}, 32'h0);
    end

    // Single VGA read, minimum latency
    vga_req   = 1'b1;
    vga_addr  = 32'h5;
    mem_rdata = 32'hFFFF_FFFF;
    tick();  // edge 0
    chk("vga_mem_req", {31'h0, mem_req}, 32'h1);
    chk("vga_grant", {30'h0, grant}, 32'h1);
    chk("vga_addr", mem_addr, 32'h5);
    chk("vga_we_bsel_wd", {mem_wdata[26:0], mem_we, mem_byte_sel}, 32'h0000_000F);
    chk("vga_busy_e0", {31'h0, vga_busy}, 32'h1);
    vga_req  = 1'b0;
    vga_addr = 32'h99;  // ignored after grant
    tick();  // edge 1
    chk("vga_mem_req_e1", {31'h0, mem_req}, 32'h0);
    chk("vga_done_e1", {31'h0, vga_done}, 32'h0);
    chk("vga_addr_hold", mem_addr, 32'h5);
    tick();  // edge 2
    chk("vga_done_e2", {31'h0, vga_done}, 32'h1);
    chk("vga_rdata", vga_rdata, 32'hFFFF_FFFF);
    chk("vga_busy_done", {31'h0, vga_busy}, 32'h0);
    chk("vga_grant_clr", {30'h0, grant}, 32'h0);
    chk("vga_err", {31'h0, err}, 32'h0);
    tick();
    chk("vga_done_pulse", {31'h0, vga_done}, 32'h0);

    // CPU write with mem_busy high for 3 cycles
    cpu_req      = 1'b1;
    cpu_we       = 1'b1;
    cpu_addr     = 32'h34;
    cpu_wdata    = 32'h0246_8ACF;
    cpu_byte_sel = 4'b0011;
    mem_rdata    = 32'hDEAD_BEEF;
    tick();  // edge 0
    chk("cpu_mem_req", {31'h0, mem_req}, 32'h1);
    chk("cpu_grant", {30'h0, grant}, 32'h2);
    chk("cpu_we", {31'h0, mem_we}, 32'h1);
    chk("cpu_addr", mem_addr, 32'h34);
    chk("cpu_wdata", mem_wdata, 32'h0246_8ACF);
    chk("cpu_bsel", {28'h0, mem_byte_sel}, 32'h3);
    cpu_req   = 1'b0;
    cpu_addr  = 32'h77;
    cpu_wdata = 32'h1;
    mem_busy  = 1'b1;
    tick();  // edge 1
    tick();  // edge 2
    chk("cpu_done_busy2", {31'h0, cpu_done}, 32'h0);
    chk("cpu_busy_hold", {31'h0, cpu_busy}, 32'h1);
    tick();  // edge 3
    chk("cpu_done_busy3", {31'h0, cpu_done}, 32'h0);
    chk("cpu_hold_addr", mem_addr, 32'h34);
    chk("cpu_hold_wdata", mem_wdata, 32'h0246_8ACF);
    mem_busy = 1'b0;
    tick();  // edge 4
    chk("cpu_done", {31'h0, cpu_done}, 32'h1);
    chk("cpu_wr_rdata", cpu_rdata, 32'h0);
    chk("cpu_wr_err", {31'h0, err}, 32'h0);
    tick();

    // Simultaneous requests with continuous VGA demand; CPU wins at wait count 8
    cpu_we    = 1'b0;
    cpu_addr  = 32'h100;
    vga_addr  = 32'h200;
    mem_rdata = 32'h1111_1111;
    vga_req   = 1'b1;
    cpu_req   = 1'b1;
    for (int e = 0; e <= 11; e++) begin
      tick();
      if (e == 0 || e == 3 || e == 6) chk("cont_grant_vga", {30'h0, grant}, 32'h1);
      if (e == 9) begin
        chk("cont_grant_cpu", {30'h0, grant}, 32'h2);
        chk("cont_cpu_addr", mem_addr, 32'h100);
        chk("cont_cpu_we", {31'h0, mem_we}, 32'h0);
      end
      if (e == 2 || e == 5 || e == 8) begin
        chk("cont_vga_done", {31'h0, vga_done}, 32'h1);
        chk("cont_vga_busy_lo", {31'h0, vga_busy}, 32'h0);
      end
      if (e == 3) chk("cont_vga_busy_hi", {31'h0, vga_busy}, 32'h1);
      if (e <= 10) chk("cont_cpu_busy", {31'h0, cpu_busy}, 32'h1);
      if (e == 11) begin
        chk("cont_cpu_done", {31'h0, cpu_done}, 32'h1);
        chk("cont_cpu_rdata", cpu_rdata, 32'h1111_1111);
        chk("cont_cpu_busy_lo", {31'h0, cpu_busy}, 32'h0);
      end
    end
    cpu_req = 1'b0;
    tick();  // edge 12: wait counter cleared, VGA resumes
    chk("cont_vga_resume", {30'h0, grant}, 32'h1);
    vga_req = 1'b0;
    tick();
    tick();
    chk("cont_last_done", {31'h0, vga_done}, 32'h1);
    tick();

    // Timeout with mem_busy stuck high
    vga_req   = 1'b1;
    vga_addr  = 32'h7;
    mem_busy  = 1'b1;
    mem_rdata = 32'h0000_ABCD;
    tick();  // edge 0
    chk("tmo_grant", {30'h0, grant}, 32'h1);
    vga_req = 1'b0;
    tick();  // edge 1: enter WAIT
    for (int e = 2; e <= 64; e++) tick();
    chk("tmo_not_yet", {31'h0, vga_done}, 32'h0);
    tick();  // edge 65: 64th WAIT cycle ends
    chk("tmo_done", {31'h0, vga_done}, 32'h1);
    chk("tmo_err", {31'h0, err}, 32'h1);
    chk("tmo_rdata", vga_rdata, 32'h0);
    chk("tmo_grant_clr", {30'h0, grant}, 32'h0);
    tick();
    chk("tmo_err_clr", {31'h0, err}, 32'h0);
    chk("tmo_idle", {31'h0, mem_req}, 32'h0);

    // Asynchronous reset mid-WAIT
    cpu_req  = 1'b1;
    cpu_addr = 32'h44;
    tick();  // edge 0
    cpu_req = 1'b0;
    tick();
    tick();
    chk("ar_in_wait", {30'h0, grant}, 32'h2);
    #2;
    nrst = 1'b0;
    #1;
    chk("ar_grant", {30'h0, grant}, 32'h0);
    chk("ar_mem_addr", mem_addr, 32'h0);
    chk("ar_flags", {26'h0, mem_req, mem_we, cpu_busy, cpu_done, vga_busy, err}, 32'h0);
    tick();
    nrst     = 1'b1;
    mem_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ar_no_launch", {30'h0, mem_req, cpu_done}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
